// File: rtl/full_adder_if.sv
// full_adder_if: operand, enable and result bundle for full_adder
// master drives X/Y/Cin/en and reads results; slave is the adder side
// Sum/Cout are combinational, Sum_q/Cout_q/valid_q are the registered copies
interface full_adder_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] X, Y, Sum, Sum_q;
  logic Cin, en, Cout, Cout_q, valid_q;
  modport master(output X, Y, Cin, en, input Sum, Cout, Sum_q, Cout_q, valid_q);
  modport slave(input X, Y, Cin, en, output Sum, Cout, Sum_q, Cout_q, valid_q);
endinterface

// File: rtl/full_adder.sv
// full_adder: ripple-carry adder of 1-bit full-adder cells with optional registered result
// clk/rst: rising-edge clock and async active-high reset, both touch the registered copies only
// io: X, Y, Cin, en in; Sum, Cout combinational out; Sum_q, Cout_q, valid_q registered out
module full_adder #(parameter int WIDTH = 1) (
  input logic clk,
  input logic rst,
  full_adder_if.slave io
);
  logic [WIDTH:0] c;
  logic [WIDTH-1:0] s, sum_q, sum_d;
  logic cout_q, cout_d, valid_q;
  assign c[0] = io.Cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i] = io.X[i] ^ io.Y[i] ^ c[i];
    assign c[i+1] = (io.X[i] & io.Y[i]) | (io.X[i] & c[i]) | (io.Y[i] & c[i]);
  end
  assign io.Sum = s;
  assign io.Cout = c[WIDTH];
  always_comb begin
    sum_d = io.en ? s : sum_q;
    cout_d = io.en ? c[WIDTH] : cout_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum_q <= '0;
      cout_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      cout_q <= cout_d;
      valid_q <= io.en;
    end
  assign io.Sum_q = sum_q;
  assign io.Cout_q = cout_q;
  assign io.valid_q = valid_q;
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench for full_adder at WIDTH 1, 8 and 16
module tb_full_adder;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0;
  int errors = 0, checks = 0;
  typedef struct { int w; logic [16:0] e; } ce_t;
  ce_t cq[$];
  logic [16:0] rq8[$], rq16[$];
  event comb_ev;
  ce_t cur;
  logic [16:0] act, e;
  logic [15:0] rx, ry;
  logic rc;

  full_adder_if #(.WIDTH(1)) i1();
  full_adder_if #(.WIDTH(8)) i8();
  full_adder_if #(.WIDTH(16)) i16();
  full_adder #(.WIDTH(1)) u1(.clk(clk), .rst(rst), .io(i1.slave));
  full_adder #(.WIDTH(8)) u8(.clk(clk), .rst(rst), .io(i8.slave));
  full_adder #(.WIDTH(16)) u16(.clk(clk), .rst(rst), .io(i16.slave));

  initial forever begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic chk(input string n, input logic [16:0] a, input logic [16:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask

  task automatic comb(input int w, input logic [15:0] x, input logic [15:0] y, input logic ci, input logic [16:0] ex);
    if (w == 1) begin
      i1.X = x[0:0]; i1.Y = y[0:0]; i1.Cin = ci;
    end else if (w == 8) begin
      i8.X = x[7:0]; i8.Y = y[7:0]; i8.Cin = ci;
    end else begin
      i16.X = x; i16.Y = y; i16.Cin = ci;
    end
    cq.push_back('{w, ex});
    ->comb_ev;
    #5;
  endtask

  initial forever begin
    @(comb_ev);
    #1;
    if (cq.size() == 0) chk("comb_queue_empty", 17'h1, 17'h0);
    else begin
      cur = cq.pop_front();
      act = cur.w == 1 ? 17'({i1.Cout, i1.Sum}) : cur.w == 8 ? 17'({i8.Cout, i8.Sum}) : {i16.Cout, i16.Sum};
      chk($sformatf("comb_w%0d", cur.w), act, cur.e);
    end
  end

  always @(negedge clk) begin
    if (i8.valid_q === 1'b1) begin
      if (rq8.size() == 0) chk("reg8_unexpected", 17'h1, 17'h0);
      else chk("reg8", 17'({i8.Cout_q, i8.Sum_q}), rq8.pop_front());
    end
    if (i16.valid_q === 1'b1) begin
      if (rq16.size() == 0) chk("reg16_unexpected", 17'h1, 17'h0);
      else chk("reg16", {i16.Cout_q, i16.Sum_q}, rq16.pop_front());
    end
  end

  initial begin
    logic [1:0] sweep [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [2:0] v;
    i1.X = '0; i1.Y = '0; i1.Cin = 0; i1.en = 0;
    i8.X = '0; i8.Y = '0; i8.Cin = 0; i8.en = 0;
    i16.X = '0; i16.Y = '0; i16.Cin = 0; i16.en = 0;
    #1;
    chk("rst_sum_q8", 17'(i8.Sum_q), 17'h0);
    chk("rst_cout_q8", 17'(i8.Cout_q), 17'h0);
    chk("rst_valid_q8", 17'(i8.valid_q), 17'h0);
    chk("rst_valid_q16", 17'(i16.valid_q), 17'h0);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      comb(1, {15'h0, v[2]}, {15'h0, v[1]}, v[0], 17'(sweep[k]));
    end
    comb(8, 16'h00FF, 16'h0000, 1'b1, 17'h100);
    comb(8, 16'h00FF, 16'h00FF, 1'b1, 17'h1FF);
    comb(8, 16'h0000, 16'h0000, 1'b0, 17'h000);
    comb(16, 16'hFFFF, 16'h0000, 1'b1, 17'h10000);
    comb(16, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    comb(16, 16'h0000, 16'h0000, 1'b0, 17'h00000);
    run = 1'b1;
    @(posedge clk); #2;
    i8.X = 8'h3C; i8.Y = 8'h44; i8.Cin = 0; i8.en = 1;
    rq8.push_back(17'h080);
    @(posedge clk); #2;
    i8.en = 0; i8.X = 8'h01; i8.Y = 8'h01;
    chk("cap_sum_q", 17'(i8.Sum_q), 17'h080);
    chk("cap_cout_q", 17'(i8.Cout_q), 17'h0);
    chk("cap_valid_q", 17'(i8.valid_q), 17'h1);
    @(posedge clk); #2;
    chk("hold_sum_q", 17'(i8.Sum_q), 17'h080);
    chk("hold_valid_q", 17'(i8.valid_q), 17'h0);
    i8.X = 8'hF0; i8.Y = 8'h20; i8.Cin = 1; i8.en = 1;
    rq8.push_back(17'h111);
    @(posedge clk); #2;
    i8.X = 8'h01; i8.Y = 8'h01; i8.Cin = 0;
    #1;
    rst = 1'b1;
    rq8.delete();
    #1;
    chk("async_rst_sum_q", 17'(i8.Sum_q), 17'h0);
    chk("async_rst_cout_q", 17'(i8.Cout_q), 17'h0);
    chk("async_rst_valid_q", 17'(i8.valid_q), 17'h0);
    comb(8, 16'h0080, 16'h0081, 1'b0, 17'h101);
    @(posedge clk); #2;
    chk("rst_hold_sum_q", 17'(i8.Sum_q), 17'h0);
    chk("rst_hold_valid_q", 17'(i8.valid_q), 17'h0);
    rst = 1'b0;
    i8.X = 8'h7F; i8.Y = 8'h01; i8.Cin = 1;
    rq8.push_back(17'h081);
    @(posedge clk); #2;
    i8.en = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #2;
      rx = 16'($urandom); ry = 16'($urandom); rc = 1'($urandom);
      i16.en = 1'($urandom);
      e = 17'(rx) + 17'(ry) + 17'(rc);
      if (i16.en) rq16.push_back(e);
      comb(16, rx, ry, rc, e);
    end
    i16.en = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("queues_drained", 17'(rq8.size() + rq16.size() + cq.size()), 17'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
